// File: rtl/div_sequencer_if.sv
// Handshake and result bundle between the EXE stage and the iterative divider.
// master = pipeline side (drives operands, consumes stall/results),
// slave  = divider side.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_signed;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             i_flush;
  logic             o_div_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_div_by_zero;

  modport master (
    output i_start, i_signed, i_dividend, i_divisor, i_flush,
    input  o_div_busy, o_done, o_quotient, o_remainder, o_div_by_zero
  );

  modport slave (
    input  i_start, i_signed, i_dividend, i_divisor, i_flush,
    output o_div_busy, o_done, o_quotient, o_remainder, o_div_by_zero
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU with its own FSM.
// Drives the pipeline stall (o_div_busy) and presents results for the single
// cycle in which busy drops (o_done).
// Optional: define DIV_EARLY_OUT_EN to skip the iteration loop when
// |dividend| < |divisor|; results are identical, only latency changes.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  div_sequencer_if.slave        bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic             signed_q,    signed_d;
  logic [WIDTH-1:0] dvd_q,       dvd_d;       // raw dividend
  logic [WIDTH-1:0] dvs_q,       dvs_d;       // raw divisor
  logic [WIDTH-1:0] dvs_mag_q,   dvs_mag_d;   // divisor magnitude
  logic [WIDTH:0]   rem_q,       rem_d;       // partial remainder
  logic [WIDTH-1:0] quo_q,       quo_d;       // dividend shifting out / quotient shifting in
  logic             neg_quo_q,   neg_quo_d;
  logic             neg_rem_q,   neg_rem_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;

  // Operand magnitudes and one restoring step, shared by the FSM below.
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted;
  logic             fits;

  assign dvd_neg = signed_q & dvd_q[WIDTH-1];
  assign dvs_neg = signed_q & dvs_q[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dvd_q : dvd_q;
  assign dvs_mag = dvs_neg ? -dvs_q : dvs_q;
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvs_mag_q});

  // Next-state and datapath computation.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    signed_d    = signed_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    dvs_mag_d   = dvs_mag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    if (bus.i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            signed_d = bus.i_signed;
            dvd_d    = bus.i_dividend;
            dvs_d    = bus.i_divisor;
            state_d  = S_PREP;
          end
        end
        S_PREP: begin
          if (dvs_q == '0) begin
            quotient_d  = '1;
            remainder_d = dvd_q;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            dvs_mag_d = dvs_mag;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            rem_d     = '0;
            quo_d     = dvd_mag;
            cnt_d     = CW'(WIDTH);
            state_d   = S_ITER;
`ifdef DIV_EARLY_OUT_EN
            if (dvd_mag < dvs_mag) begin
              quo_d   = '0;
              rem_d   = {1'b0, dvd_mag};
              state_d = S_FIX;
            end
`endif
          end
        end
        S_ITER: begin
          rem_d = fits ? (shifted - {1'b0, dvs_mag_q}) : shifted;
          quo_d = {quo_q[WIDTH-2:0], fits};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          // -2^(W-1) / -1: magnitude 2^(W-1) negated wraps to itself, remainder 0.
          quotient_d  = neg_quo_q ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          dbz_d       = 1'b0;
          state_d     = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      dvs_mag_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      signed_q    <= signed_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      dvs_mag_q   <= dvs_mag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Stall is combinational so the issue cycle itself already stalls; flush kills it.
  assign bus.o_div_busy    = ~bus.i_flush &
                             ((state_q == S_IDLE) ? bus.i_start
                                                  : (state_q == S_PREP) || (state_q == S_ITER) ||
                                                    (state_q == S_FIX));
  assign bus.o_done        = (state_q == S_DONE);
  assign bus.o_quotient    = quotient_q;
  assign bus.o_remainder   = remainder_q;
  assign bus.o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed table, flush/reset/back-to-back
// sequences, and random operations against an arithmetic reference model.
module tb_div_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder follows dividend.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (!sgn) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0;
    end
  endfunction

  // Cycle (relative to issue) at which o_done is expected.
  function automatic int model_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = (sgn && a[31]) ? -longint'($signed(a)) : longint'(a);
    mb = (sgn && b[31]) ? -longint'($signed(b)) : longint'(b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 3;
`endif
    return 35;
  endfunction

  // Issue one operation (caller is 1ns after a rising edge), wait for o_done,
  // check busy/latency, return results. Leaves the bench in the IDLE cycle after DONE.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z,
                       output int done_cyc);
    int lat;
    int exp_lat;
    logic busy_ok;
    lat = -1;
    busy_ok = 1'b1;
    q = '0; r = '0; z = 1'b0; done_cyc = 0;
    exp_lat = model_lat(sgn, a, b);
    bus.i_signed = sgn; bus.i_dividend = a; bus.i_divisor = b; bus.i_start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) begin
        lat = c;
        q = bus.o_quotient; r = bus.o_remainder; z = bus.o_div_by_zero;
        done_cyc = cyc;
        if (bus.o_div_busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.o_div_busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check("busy_pattern", 32'(busy_ok), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic idle_no_done(input int n, input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (bus.o_done !== 1'b0 || bus.o_div_busy !== 1'b0) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] q, r, q2, r2, eq, er;
    logic        z, z2, ez;
    int          d1, d2;

    vecs[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
    vecs[4] = '{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1};
    vecs[5] = '{1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
    vecs[8] = '{1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFFD, 1'b0};
    vecs[9] = '{1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0};

    bus.i_start = 1'b0; bus.i_signed = 1'b0; bus.i_flush = 1'b0;
    bus.i_dividend = '0; bus.i_divisor = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(bus.o_div_busy), 32'd0);
    check("reset_done", 32'(bus.o_done), 32'd0);
    check("reset_quo",  bus.o_quotient, 32'd0);
    check("reset_rem",  bus.o_remainder, 32'd0);
    check("reset_dbz",  32'(bus.o_div_by_zero), 32'd0);
    @(posedge clk); #1;

    // Directed table.
    foreach (vecs[i]) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, z, d1);
      check($sformatf("vec%0d_quo", i), q, vecs[i].q);
      check($sformatf("vec%0d_rem", i), r, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("vec%0d_hold_quo", i), bus.o_quotient, vecs[i].q);
    end

    // Back-to-back: second done exactly 36 cycles after the first.
    do_op(1'b0, 32'd100, 32'd7, q, r, z, d1);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd3, q2, r2, z2, d2);
    check("b2b_q1", q, 32'd14);
    check("b2b_r1", r, 32'd2);
    check("b2b_q2", q2, 32'h5555_5555);
    check("b2b_r2", r2, 32'd0);
    check("b2b_spacing", 32'(d2 - d1), 32'd36);

    // Flush at cycle 10: busy drops at once, no done, results retained.
    bus.i_signed = 1'b0; bus.i_dividend = 32'd1000; bus.i_divisor = 32'd3; bus.i_start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    bus.i_flush = 1'b1;
    #1 check("flush_busy_comb", 32'(bus.o_div_busy), 32'd0);
    @(posedge clk); #1;
    bus.i_flush = 1'b0; bus.i_start = 1'b0;
    idle_no_done(40, "flush_no_done");
    check("flush_keep_quo", bus.o_quotient, 32'h5555_5555);
    check("flush_keep_rem", bus.o_remainder, 32'd0);

    // Reset at cycle 20 of another DIVU: IDLE, outputs zero next cycle.
    bus.i_signed = 1'b0; bus.i_dividend = 32'd77; bus.i_divisor = 32'd5; bus.i_start = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.i_start = 1'b0;
    @(negedge clk);
    check("rst_mid_quo", bus.o_quotient, 32'd0);
    check("rst_mid_rem", bus.o_remainder, 32'd0);
    check("rst_mid_dbz", 32'(bus.o_div_by_zero), 32'd0);
    check("rst_mid_busy", 32'(bus.o_div_busy), 32'd0);
    @(posedge clk); #1;
    idle_no_done(40, "rst_no_done");

    // Random operations against the model.
    for (int k = 0; k < 40; k++) begin
      logic        sgn;
      logic [31:0] a, b;
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      model(sgn, a, b, eq, er, ez);
      do_op(sgn, a, b, q, r, z, d1);
      check($sformatf("rnd%0d_quo", k), q, eq);
      check($sformatf("rnd%0d_rem", k), r, er);
      check($sformatf("rnd%0d_dbz", k), 32'(z), 32'(ez));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
